// File: rtl/d_strobe_pkg.sv
// d_strobe_pkg: state encoding shared by the strobed serial transmitter.
package d_strobe_pkg;
    typedef enum logic [1:0] {IDLE, LOW, HIGH, HOLD} state_e;
endpackage

// File: rtl/strobe_div.sv
// strobe_div: half-phase counter, terminal count after HALF_DIV cycles since the last clear.
module strobe_div #(
    parameter int HALF_DIV = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    output logic tc
);
    localparam int CW = $clog2(HALF_DIV);
    logic [CW-1:0] cnt_q, cnt_d;
    assign cnt_d = clear ? '0 : cnt_q + CW'(1);
    assign tc = cnt_q == CW'(HALF_DIV - 1);
    always_ff @(posedge clk) begin
        if (!resetn) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/d_strobe_tx.sv
// d_strobe_tx: MSB-first serializer with a generated strobe; data is stable across both strobe edges.
// Defining PARITY_EN appends an even-parity bit after the LSB.
module d_strobe_tx
    import d_strobe_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int HALF_DIV = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic             d_out,
    output logic             strobe_out,
    output logic             done
);
`ifdef PARITY_EN
    localparam int NB = WIDTH + 1;
`else
    localparam int NB = WIDTH;
`endif
    localparam int IW = NB > 1 ? $clog2(NB) : 1;
    state_e state_q, state_d;
    logic [NB-1:0] sh_q, sh_d, word;
    logic [IW-1:0] idx_q, idx_d;
    logic d_q, d_d, strobe_q, done_q, tc, clear;
`ifdef PARITY_EN
    assign word = {data_in, ^data_in};
`else
    assign word = data_in;
`endif
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        unique case (state_q)
            IDLE: if (load) begin
                state_d = LOW;
                idx_d   = IW'(NB - 1);
                sh_d    = word;
            end
            LOW:  state_d = tc ? HIGH : LOW;
            HIGH: state_d = tc ? HOLD : HIGH;
            HOLD: begin
                state_d = idx_q == '0 ? IDLE : LOW;
                idx_d   = idx_q == '0 ? idx_q : idx_q - IW'(1);
            end
            default: state_d = IDLE;
        endcase
    end
    // d_out moves only when a LOW phase begins, so both strobe edges see the same bit
    assign clear = state_d != state_q || state_q == IDLE;
    assign d_d = state_d == IDLE ? 1'b0 :
                 (state_d == LOW && state_q != LOW) ? sh_d[idx_d] : d_q;
    strobe_div #(.HALF_DIV(HALF_DIV)) u_div (
        .clk    (clk),
        .resetn (resetn),
        .clear  (clear),
        .tc     (tc)
    );
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            sh_q     <= '0;
            idx_q    <= '0;
            d_q      <= 1'b0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            idx_q    <= idx_d;
            d_q      <= d_d;
            strobe_q <= state_d == HIGH;
            done_q   <= state_d == HOLD && idx_d == '0;
        end
    end
    assign ready      = state_q == IDLE;
    assign d_out      = d_q;
    assign strobe_out = strobe_q;
    assign done       = done_q;
endmodule

// File: doc/d_strobe_tx.md
D_STROBE_TX -- requirements
Module: d_strobe_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of data bits per word.
REQ-002 SHALL have parameter HALF_DIV, default 4, clk cycles per strobe half-phase; legal minimum 2.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-004 SHALL have port resetn  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port load  input  1  request to transmit data_in; sampled only when ready=1.
REQ-006 SHALL have port data_in  input  WIDTH  parallel word to serialize.
REQ-007 SHALL have port ready  output  1  high only in IDLE; load accepted when load&ready at a clk edge.
REQ-008 SHALL have port d_out  output  1  serial data line, intended to drive D of a latch or flip-flop.
REQ-009 SHALL have port strobe_out  output  1  generated strobe, intended to drive the clk of that latch or flip-flop.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking the final cycle of a word.

Function
REQ-011 SHALL implement the states IDLE, LOW, HIGH and HOLD.
REQ-012 IDLE SHALL hold d_out=0, strobe_out=0 and ready=1; on load acceptance, SHALL latch data_in into a shift register, load bit index WIDTH-1, and go to LOW.
REQ-013 LOW SHALL last HALF_DIV cycles, with strobe_out=0 and d_out=current bit, then go to HIGH.
REQ-014 HIGH SHALL last HALF_DIV cycles, with strobe_out=1 and d_out unchanged, then go to HOLD.
REQ-015 HOLD SHALL last 1 cycle, with strobe_out=0 and d_out unchanged; then, if bits remain, SHALL decrement the index and go to LOW, else go to IDLE.
REQ-016 d_out SHALL change only on entry to LOW, so that it is stable throughout HIGH and on both strobe edges; a transparent-high latch, a posedge flip-flop and a negedge flip-flop all capture the same bit.
REQ-017 Bits SHALL be sent MSB first; bit period SHALL be 2*HALF_DIV+1 cycles; word latency from acceptance to done SHALL be WIDTH*(2*HALF_DIV+1) cycles.
REQ-018 done SHALL be 1 exactly during the last HOLD cycle of a word, else 0.
REQ-019 load while not in IDLE SHALL be ignored; data_in changes after acceptance SHALL have no effect.
REQ-020 A load asserted in the cycle after done SHALL be accepted, giving back-to-back words with one IDLE cycle between them.
REQ-021 The half-phase counter SHALL be ceil(log2(HALF_DIV)) bits wide and SHALL reset to 0 on every state change.

Reset
REQ-022 When resetn=0 at a clk edge, the block SHALL enter IDLE with d_out=0, strobe_out=0, done=0, ready=1, and counter and index at 0.
REQ-023 Reset mid-word SHALL abandon the word: no done pulse and no further strobe edges.

Configuration
REQ-024 With PARITY_EN defined, one even-parity bit (XOR of the word) SHALL follow the LSB as an extra LOW/HIGH/HOLD period; latency becomes (WIDTH+1)*(2*HALF_DIV+1) cycles.
REQ-025 Without PARITY_EN, exactly WIDTH bits SHALL be sent and no parity logic SHALL exist.

Structure
REQ-026 The state enum (IDLE, LOW, HIGH, HOLD) SHALL live in shared package d_strobe_pkg.
REQ-027 The half-phase counter SHALL be the sub-module strobe_div, with inputs clk, resetn, clear and outputs terminal-count.

Verification
REQ-028 Scenario: WIDTH=8, HALF_DIV=4, load 8'hA5 -> 8 strobe rising edges, with d_out at each edge 1,0,1,0,0,1,0,1, done at cycle 72 after acceptance, and a posedge shift-register model holding 8'hA5.
REQ-029 Scenario: same stimulus with a negedge flip-flop model and a transparent-high latch model -> both end holding the last bit 1 and sample the same sequence.
REQ-030 Scenario: load 8'h3C, then pulse load with 8'hFF at cycle 10 -> only 8'h3C is transmitted and ready=0 until IDLE.
REQ-031 Scenario: load 8'hFF, resetn=0 at cycle 20 -> next cycle d_out=0, strobe_out=0, ready=1, and done is never pulsed.
REQ-032 Scenario: load 8'h81, then reassert load with 8'h7E in the cycle after done -> second word starts with no lost bits.
REQ-033 Scenario: PARITY_EN with load 8'hA5 -> 9 strobe edges, the 9th carrying parity 0; with 8'hA4 the 9th carries 1.
